// File: rtl/tcdm2axi_pkg.sv
// Shared FSM state type and AXI4 encodings used by the TCDM-to-AXI bridge.
package tcdm2axi_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWrReq,
      StWrResp,
      StRdReq,
      StRdResp,
      StRsp
   } state_e;

   localparam logic [2:0] SIZE_WORD   = 3'b010;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/tcdm2axi_bridge.sv
// Bridges single TCDM word accesses onto single-beat AXI4 transactions,
// one transaction outstanding at a time.
module tcdm2axi_bridge
   import tcdm2axi_pkg::*;
#(
   parameter int unsigned                AXI_ADDR_WIDTH = 64,
   parameter int unsigned                AXI_DATA_WIDTH = 64,
   parameter int unsigned                AXI_ID_WIDTH   = 6,
   parameter int unsigned                AXI_USER_WIDTH = 6,
   parameter logic [AXI_ID_WIDTH-1:0]    AXI_ID         = '0
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   // TCDM slave port
   input  logic                          tcdm_req_i,
   input  logic [31:0]                   tcdm_add_i,
   input  logic                          tcdm_wen_i,
   input  logic [31:0]                   tcdm_wdata_i,
   input  logic [3:0]                    tcdm_be_i,
   output logic                          tcdm_gnt_o,
   output logic                          tcdm_r_valid_o,
   output logic [31:0]                   tcdm_r_rdata_o,
   // AXI write address channel
   output logic [AXI_ID_WIDTH-1:0]       aw_id_o,
   output logic [AXI_ADDR_WIDTH-1:0]     aw_addr_o,
   output logic [7:0]                    aw_len_o,
   output logic [2:0]                    aw_size_o,
   output logic [1:0]                    aw_burst_o,
   output logic                          aw_lock_o,
   output logic [3:0]                    aw_cache_o,
   output logic [2:0]                    aw_prot_o,
   output logic [3:0]                    aw_qos_o,
   output logic [3:0]                    aw_region_o,
   output logic [5:0]                    aw_atop_o,
   output logic [AXI_USER_WIDTH-1:0]     aw_user_o,
   output logic                          aw_valid_o,
   input  logic                          aw_ready_i,
   // AXI write data channel
   output logic [AXI_DATA_WIDTH-1:0]     w_data_o,
   output logic [AXI_DATA_WIDTH/8-1:0]   w_strb_o,
   output logic                          w_last_o,
   output logic [AXI_USER_WIDTH-1:0]     w_user_o,
   output logic                          w_valid_o,
   input  logic                          w_ready_i,
   // AXI write response channel
   input  logic [AXI_ID_WIDTH-1:0]       b_id_i,
   input  logic [1:0]                    b_resp_i,
   input  logic [AXI_USER_WIDTH-1:0]     b_user_i,
   input  logic                          b_valid_i,
   output logic                          b_ready_o,
   // AXI read address channel
   output logic [AXI_ID_WIDTH-1:0]       ar_id_o,
   output logic [AXI_ADDR_WIDTH-1:0]     ar_addr_o,
   output logic [7:0]                    ar_len_o,
   output logic [2:0]                    ar_size_o,
   output logic [1:0]                    ar_burst_o,
   output logic                          ar_lock_o,
   output logic [3:0]                    ar_cache_o,
   output logic [2:0]                    ar_prot_o,
   output logic [3:0]                    ar_qos_o,
   output logic [3:0]                    ar_region_o,
   output logic [AXI_USER_WIDTH-1:0]     ar_user_o,
   output logic                          ar_valid_o,
   input  logic                          ar_ready_i,
   // AXI read data channel
   input  logic [AXI_ID_WIDTH-1:0]       r_id_i,
   input  logic [AXI_DATA_WIDTH-1:0]     r_data_i,
   input  logic [1:0]                    r_resp_i,
   input  logic                          r_last_i,
   input  logic [AXI_USER_WIDTH-1:0]     r_user_i,
   input  logic                          r_valid_i,
   output logic                          r_ready_o,
   // Status
   output logic                          busy_o,
   output logic                          err_o
);

   localparam int unsigned NumLanes = AXI_DATA_WIDTH / 32;
   localparam int unsigned LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1;
   localparam int unsigned StrbW    = AXI_DATA_WIDTH / 8;

   state_e      state_q, state_d;
   logic [31:0] add_q, add_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        wen_q, wen_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;

   logic [LaneW-1:0] lane;
   logic [StrbW-1:0] strb_base;

   // A 32-bit AXI bus has a single lane and no lane bits in the address.
   if (NumLanes > 1) begin : g_lane
      assign lane = add_q[LaneW+1:2];
   end else begin : g_no_lane
      assign lane = '0;
   end

   assign strb_base = StrbW'(be_q);

   assign aw_id_o     = AXI_ID;
   assign aw_addr_o   = AXI_ADDR_WIDTH'(add_q);
   assign aw_len_o    = 8'd0;
   assign aw_size_o   = SIZE_WORD;
   assign aw_burst_o  = BURST_INCR;
   assign aw_lock_o   = 1'b0;
   assign aw_cache_o  = 4'd0;
   assign aw_prot_o   = 3'd0;
   assign aw_qos_o    = 4'd0;
   assign aw_region_o = 4'd0;
   assign aw_atop_o   = 6'd0;
   assign aw_user_o   = '0;

   assign w_data_o    = {NumLanes{wdata_q}};
   assign w_strb_o    = strb_base << {lane, 2'b00};
   assign w_last_o    = 1'b1;
   assign w_user_o    = '0;

   assign ar_id_o     = AXI_ID;
   assign ar_addr_o   = AXI_ADDR_WIDTH'(add_q);
   assign ar_len_o    = 8'd0;
   assign ar_size_o   = SIZE_WORD;
   assign ar_burst_o  = BURST_INCR;
   assign ar_lock_o   = 1'b0;
   assign ar_cache_o  = 4'd0;
   assign ar_prot_o   = 3'd0;
   assign ar_qos_o    = 4'd0;
   assign ar_region_o = 4'd0;
   assign ar_user_o   = '0;

   assign busy_o = (state_q != StIdle);

   // IDs, user bits, rlast and the low response bit carry no information here.
   logic unused_inputs;
   assign unused_inputs = ^{b_id_i, b_user_i, b_resp_i[0], r_id_i, r_user_i, r_last_i,
                            r_resp_i[0]};

   always_comb begin
      state_d        = state_q;
      add_d          = add_q;
      wdata_d        = wdata_q;
      be_d           = be_q;
      wen_d          = wen_q;
      aw_done_d      = aw_done_q;
      w_done_d       = w_done_q;
      err_d          = err_q;
      rdata_d        = rdata_q;
      tcdm_gnt_o     = 1'b0;
      tcdm_r_valid_o = 1'b0;
      tcdm_r_rdata_o = '0;
      aw_valid_o     = 1'b0;
      w_valid_o      = 1'b0;
      b_ready_o      = 1'b0;
      ar_valid_o     = 1'b0;
      r_ready_o      = 1'b0;
      err_o          = 1'b0;

      unique case (state_q)
         StIdle: begin
            tcdm_gnt_o = tcdm_req_i && !rst_i;
            if (tcdm_req_i) begin
               add_d     = tcdm_add_i;
               wdata_d   = tcdm_wdata_i;
               be_d      = tcdm_be_i;
               wen_d     = tcdm_wen_i;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = tcdm_wen_i ? StRdReq : StWrReq;
            end
         end
         StWrReq: begin
            aw_valid_o = !aw_done_q;
            w_valid_o  = !w_done_q;
            if (aw_valid_o && aw_ready_i) aw_done_d = 1'b1;
            if (w_valid_o && w_ready_i)   w_done_d  = 1'b1;
            if (aw_done_d && w_done_d)    state_d   = StWrResp;
         end
         StWrResp: begin
            b_ready_o = 1'b1;
            if (b_valid_i) begin
               err_d   = b_resp_i[1];
               state_d = StRsp;
            end
         end
         StRdReq: begin
            ar_valid_o = 1'b1;
            if (ar_ready_i) state_d = StRdResp;
         end
         StRdResp: begin
            r_ready_o = 1'b1;
            if (r_valid_i) begin
               err_d   = r_resp_i[1];
               rdata_d = r_data_i[{lane, 5'b00000} +: 32];
               state_d = StRsp;
            end
         end
         StRsp: begin
            tcdm_r_valid_o = 1'b1;
            tcdm_r_rdata_o = wen_q ? rdata_q : 32'd0;
            err_o          = err_q;
            state_d        = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         add_q     <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         wen_q     <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         add_q     <= add_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         wen_q     <= wen_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

endmodule

// File: tb/tb_tcdm2axi_bridge.sv
// Directed self-checking bench for tcdm2axi_bridge with a 64-bit AXI bus.
module tb_tcdm2axi_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        tcdm_req, tcdm_wen, tcdm_gnt, tcdm_rv;
   logic [31:0] tcdm_add, tcdm_wdata, tcdm_rdata;
   logic [3:0]  tcdm_be;

   logic [5:0]  aw_id, aw_atop, aw_user, w_user, b_id, b_user, ar_id, ar_user, r_id, r_user;
   logic [63:0] aw_addr, ar_addr, w_data, r_data;
   logic [7:0]  aw_len, ar_len, w_strb;
   logic [2:0]  aw_size, aw_prot, ar_size, ar_prot;
   logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
   logic [3:0]  aw_cache, aw_qos, aw_region, ar_cache, ar_qos, ar_region;
   logic        aw_lock, aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
   logic        ar_lock, ar_valid, ar_ready, r_last, r_valid, r_ready, busy, err;

   int n_cmp = 0;
   int n_fail = 0;
   int aw_hs_cnt = 0;
   int w_hs_cnt = 0;
   int err_cnt = 0;

   tcdm2axi_bridge dut (
      .clk_i(clk), .rst_i(rst),
      .tcdm_req_i(tcdm_req), .tcdm_add_i(tcdm_add), .tcdm_wen_i(tcdm_wen),
      .tcdm_wdata_i(tcdm_wdata), .tcdm_be_i(tcdm_be), .tcdm_gnt_o(tcdm_gnt),
      .tcdm_r_valid_o(tcdm_rv), .tcdm_r_rdata_o(tcdm_rdata),
      .aw_id_o(aw_id), .aw_addr_o(aw_addr), .aw_len_o(aw_len), .aw_size_o(aw_size),
      .aw_burst_o(aw_burst), .aw_lock_o(aw_lock), .aw_cache_o(aw_cache), .aw_prot_o(aw_prot),
      .aw_qos_o(aw_qos), .aw_region_o(aw_region), .aw_atop_o(aw_atop), .aw_user_o(aw_user),
      .aw_valid_o(aw_valid), .aw_ready_i(aw_ready),
      .w_data_o(w_data), .w_strb_o(w_strb), .w_last_o(w_last), .w_user_o(w_user),
      .w_valid_o(w_valid), .w_ready_i(w_ready),
      .b_id_i(b_id), .b_resp_i(b_resp), .b_user_i(b_user), .b_valid_i(b_valid),
      .b_ready_o(b_ready),
      .ar_id_o(ar_id), .ar_addr_o(ar_addr), .ar_len_o(ar_len), .ar_size_o(ar_size),
      .ar_burst_o(ar_burst), .ar_lock_o(ar_lock), .ar_cache_o(ar_cache), .ar_prot_o(ar_prot),
      .ar_qos_o(ar_qos), .ar_region_o(ar_region), .ar_user_o(ar_user),
      .ar_valid_o(ar_valid), .ar_ready_i(ar_ready),
      .r_id_i(r_id), .r_data_i(r_data), .r_resp_i(r_resp), .r_last_i(r_last),
      .r_user_i(r_user), .r_valid_i(r_valid), .r_ready_o(r_ready),
      .busy_o(busy), .err_o(err)
   );

   initial forever #5 clk = ~clk;

   // Inputs change 1ns after posedge, so negedge sees what the next posedge will take.
   always @(negedge clk) begin
      if (!rst) begin
         if (aw_valid && aw_ready) aw_hs_cnt <= aw_hs_cnt + 1;
         if (w_valid && w_ready)   w_hs_cnt  <= w_hs_cnt + 1;
         if (err)                  err_cnt   <= err_cnt + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic [31:0] add, input logic wen, input logic [31:0] wd,
                            input logic [3:0] be);
      tcdm_req = 1'b1; tcdm_add = add; tcdm_wen = wen; tcdm_wdata = wd; tcdm_be = be;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tcdm_req = 1'b1; tcdm_wen = 1'b1; tcdm_add = 32'h0;
      tick(); tick();
      n_cmp++; if (tcdm_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %b want 0", tcdm_gnt); end
      n_cmp++; if ({aw_valid, w_valid, ar_valid} !== 3'b000) begin n_fail++; $display("FAIL rst_valids: got %b want 000", {aw_valid, w_valid, ar_valid}); end
      n_cmp++; if ({b_ready, r_ready} !== 2'b00) begin n_fail++; $display("FAIL rst_readys: got %b want 00", {b_ready, r_ready}); end
      n_cmp++; if ({tcdm_rv, err, busy} !== 3'b000) begin n_fail++; $display("FAIL rst_status: got %b want 000", {tcdm_rv, err, busy}); end
      n_cmp++; if (tcdm_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", tcdm_rdata); end
      tcdm_req = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_write();
      aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; b_resp = 2'b00;
      drive_req(32'h1000_0004, 1'b0, 32'hDEAD_BEEF, 4'hF);
      n_cmp++; if (tcdm_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b want 1", tcdm_gnt); end
      tick(); tcdm_req = 1'b0;
      n_cmp++; if ({aw_valid, w_valid} !== 2'b11) begin n_fail++; $display("FAIL wr_valids: got %b want 11", {aw_valid, w_valid}); end
      n_cmp++; if (aw_addr !== 64'h1000_0004) begin n_fail++; $display("FAIL wr_awaddr: got %h want 10000004", aw_addr); end
      n_cmp++; if ({aw_size, aw_len, aw_burst} !== {3'd2, 8'd0, 2'b01}) begin n_fail++; $display("FAIL wr_awfmt: got %h/%h/%h want 2/0/1", aw_size, aw_len, aw_burst); end
      n_cmp++; if ({aw_id, aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_atop, aw_user, w_user} !== 40'h0) begin n_fail++; $display("FAIL wr_awzero: aw side fields not all zero"); end
      n_cmp++; if (w_data !== 64'hDEADBEEF_DEADBEEF) begin n_fail++; $display("FAIL wr_wdata: got %h want deadbeefdeadbeef", w_data); end
      n_cmp++; if ({w_strb, w_last} !== {8'hF0, 1'b1}) begin n_fail++; $display("FAIL wr_wstrb: got %h/%b want f0/1", w_strb, w_last); end
      tick();
      n_cmp++; if ({b_ready, aw_valid, w_valid, tcdm_rv} !== 4'b1000) begin n_fail++; $display("FAIL wr_bphase: got %b want 1000", {b_ready, aw_valid, w_valid, tcdm_rv}); end
      tick();
      n_cmp++; if ({tcdm_rv, err, busy} !== 3'b101) begin n_fail++; $display("FAIL wr_rsp: got %b want 101", {tcdm_rv, err, busy}); end
      n_cmp++; if (tcdm_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rdata: got %h want 0", tcdm_rdata); end
      tick();
      n_cmp++; if ({tcdm_rv, busy} !== 2'b00) begin n_fail++; $display("FAIL wr_idle: got %b want 00", {tcdm_rv, busy}); end
      b_valid = 1'b0;
   endtask

   task automatic test_read();
      logic [31:0] adds [2];
      logic [31:0] exps [2];
      adds[0] = 32'h2000_0000; exps[0] = 32'h5566_7788;
      adds[1] = 32'h2000_0004; exps[1] = 32'h1122_3344;
      ar_ready = 1'b1; r_valid = 1'b1; r_resp = 2'b00; r_last = 1'b1;
      r_data = 64'h11223344_55667788;
      for (int i = 0; i < 2; i++) begin
         drive_req(adds[i], 1'b1, 32'h0, 4'hF);
         n_cmp++; if (tcdm_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt[%0d]: got %b want 1", i, tcdm_gnt); end
         tick(); tcdm_req = 1'b0;
         n_cmp++; if ({ar_valid, ar_addr} !== {1'b1, 32'h0, adds[i]}) begin n_fail++; $display("FAIL rd_ar[%0d]: got %b/%h want 1/%h", i, ar_valid, ar_addr, adds[i]); end
         n_cmp++; if ({ar_size, ar_len, ar_burst, ar_id, ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user} !== {3'd2, 8'd0, 2'b01, 28'h0}) begin n_fail++; $display("FAIL rd_arfmt[%0d]: fields wrong", i); end
         tick();
         n_cmp++; if ({r_ready, ar_valid, tcdm_rv} !== 3'b100) begin n_fail++; $display("FAIL rd_rphase[%0d]: got %b want 100", i, {r_ready, ar_valid, tcdm_rv}); end
         tick();
         n_cmp++; if ({tcdm_rv, err, tcdm_rdata} !== {2'b10, exps[i]}) begin n_fail++; $display("FAIL rd_rsp[%0d]: got %b/%b/%h want 1/0/%h", i, tcdm_rv, err, tcdm_rdata, exps[i]); end
         tick();
         n_cmp++; if ({tcdm_rv, busy} !== 2'b00) begin n_fail++; $display("FAIL rd_idle[%0d]: got %b want 00", i, {tcdm_rv, busy}); end
      end
      r_valid = 1'b0;
   endtask

   task automatic test_aw_backpressure();
      int aw_base, w_base;
      aw_base = aw_hs_cnt; w_base = w_hs_cnt;
      aw_ready = 1'b0; w_ready = 1'b1; b_valid = 1'b1; b_resp = 2'b00;
      drive_req(32'h3000_0008, 1'b0, 32'hCAFE_F00D, 4'h3);
      tick(); tcdm_req = 1'b0;
      n_cmp++; if ({aw_valid, w_valid, w_strb} !== {2'b11, 8'h03}) begin n_fail++; $display("FAIL bp_start: got %b%b/%h want 11/03", aw_valid, w_valid, w_strb); end
      for (int c = 2; c <= 5; c++) begin
         tick();
         n_cmp++; if ({aw_valid, w_valid, tcdm_rv} !== 3'b100) begin n_fail++; $display("FAIL bp_hold[%0d]: got %b want 100", c, {aw_valid, w_valid, tcdm_rv}); end
      end
      tick();
      aw_ready = 1'b1;
      n_cmp++; if ({aw_valid, aw_addr} !== {1'b1, 64'h3000_0008}) begin n_fail++; $display("FAIL bp_aw: got %b/%h want 1/30000008", aw_valid, aw_addr); end
      tick();
      n_cmp++; if ({b_ready, aw_valid, tcdm_rv} !== 3'b100) begin n_fail++; $display("FAIL bp_b: got %b want 100", {b_ready, aw_valid, tcdm_rv}); end
      tick();
      n_cmp++; if (tcdm_rv !== 1'b1) begin n_fail++; $display("FAIL bp_rsp: got %b want 1", tcdm_rv); end
      tick();
      n_cmp++; if (aw_hs_cnt - aw_base !== 1) begin n_fail++; $display("FAIL bp_awcount: got %0d want 1", aw_hs_cnt - aw_base); end
      n_cmp++; if (w_hs_cnt - w_base !== 1) begin n_fail++; $display("FAIL bp_wcount: got %0d want 1", w_hs_cnt - w_base); end
      b_valid = 1'b0;
   endtask

   task automatic test_error();
      int err_base;
      err_base = err_cnt;
      aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; b_resp = 2'b10;
      drive_req(32'h4000_0000, 1'b0, 32'h1234_5678, 4'hF);
      tick(); tcdm_req = 1'b0;
      tick(); tick();
      n_cmp++; if ({tcdm_rv, err} !== 2'b11) begin n_fail++; $display("FAIL err_wr: got %b want 11", {tcdm_rv, err}); end
      tick();
      n_cmp++; if ({err, busy} !== 2'b00) begin n_fail++; $display("FAIL err_wr_after: got %b want 00", {err, busy}); end
      b_valid = 1'b0; b_resp = 2'b00;
      ar_ready = 1'b1; r_valid = 1'b1; r_resp = 2'b11; r_data = 64'h0;
      drive_req(32'h4000_0004, 1'b1, 32'h0, 4'hF);
      tick(); tcdm_req = 1'b0;
      tick(); tick();
      n_cmp++; if ({tcdm_rv, err} !== 2'b11) begin n_fail++; $display("FAIL err_rd: got %b want 11", {tcdm_rv, err}); end
      tick();
      n_cmp++; if ({err, busy} !== 2'b00) begin n_fail++; $display("FAIL err_rd_after: got %b want 00", {err, busy}); end
      n_cmp++; if (err_cnt - err_base !== 2) begin n_fail++; $display("FAIL err_count: got %0d want 2", err_cnt - err_base); end
      r_valid = 1'b0; r_resp = 2'b00;
   endtask

   task automatic test_busy_req();
      aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b0; b_resp = 2'b00;
      ar_ready = 1'b1; r_valid = 1'b1; r_resp = 2'b00; r_data = 64'hA5A5A5A5_5A5A5A5A;
      drive_req(32'h5000_0000, 1'b0, 32'h0F0F_0F0F, 4'hF);
      n_cmp++; if (tcdm_gnt !== 1'b1) begin n_fail++; $display("FAIL busy_gnt0: got %b want 1", tcdm_gnt); end
      tick(); tcdm_req = 1'b0;
      tick();
      drive_req(32'h5000_0004, 1'b1, 32'h0, 4'hF);
      n_cmp++; if ({b_ready, tcdm_gnt} !== 2'b10) begin n_fail++; $display("FAIL busy_wresp_gnt: got %b want 10", {b_ready, tcdm_gnt}); end
      tick();
      b_valid = 1'b1;
      n_cmp++; if (tcdm_gnt !== 1'b0) begin n_fail++; $display("FAIL busy_wait_gnt: got %b want 0", tcdm_gnt); end
      tick();
      b_valid = 1'b0;
      n_cmp++; if ({tcdm_rv, tcdm_gnt, tcdm_rdata} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL busy_rsp1: got %b/%b/%h want 1/0/0", tcdm_rv, tcdm_gnt, tcdm_rdata); end
      tick();
      n_cmp++; if ({tcdm_gnt, tcdm_rv} !== 2'b10) begin n_fail++; $display("FAIL busy_gnt1: got %b want 10", {tcdm_gnt, tcdm_rv}); end
      tick(); tcdm_req = 1'b0;
      n_cmp++; if ({ar_valid, ar_addr} !== {1'b1, 64'h5000_0004}) begin n_fail++; $display("FAIL busy_ar: got %b/%h want 1/50000004", ar_valid, ar_addr); end
      tick(); tick();
      n_cmp++; if ({tcdm_rv, tcdm_rdata} !== {1'b1, 32'hA5A5_A5A5}) begin n_fail++; $display("FAIL busy_rsp2: got %b/%h want 1/a5a5a5a5", tcdm_rv, tcdm_rdata); end
      tick();
      n_cmp++; if ({tcdm_rv, busy} !== 2'b00) begin n_fail++; $display("FAIL busy_idle: got %b want 00", {tcdm_rv, busy}); end
      r_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      ar_ready = 1'b1; r_valid = 1'b0; r_resp = 2'b00;
      drive_req(32'h6000_0000, 1'b1, 32'h0, 4'hF);
      tick(); tcdm_req = 1'b0;
      tick();
      n_cmp++; if (r_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rready: got %b want 1", r_ready); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if ({ar_valid, r_ready, aw_valid, w_valid, b_ready, busy, tcdm_rv} !== 7'b0) begin n_fail++; $display("FAIL mid_after_rst: got %b want 0000000", {ar_valid, r_ready, aw_valid, w_valid, b_ready, busy, tcdm_rv}); end
      r_valid = 1'b1; r_data = 64'h0BADF00D_12345678;
      tick();
      n_cmp++; if ({tcdm_rv, busy} !== 2'b00) begin n_fail++; $display("FAIL mid_no_rsp: got %b want 00", {tcdm_rv, busy}); end
      drive_req(32'h6000_0000, 1'b1, 32'h0, 4'hF);
      n_cmp++; if (tcdm_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_regnt: got %b want 1", tcdm_gnt); end
      tick(); tcdm_req = 1'b0;
      tick(); tick();
      n_cmp++; if ({tcdm_rv, tcdm_rdata} !== {1'b1, 32'h1234_5678}) begin n_fail++; $display("FAIL mid_read: got %b/%h want 1/12345678", tcdm_rv, tcdm_rdata); end
      tick();
      r_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      tcdm_req = 1'b0; tcdm_wen = 1'b1; tcdm_add = '0; tcdm_wdata = '0; tcdm_be = '0;
      aw_ready = 1'b0; w_ready = 1'b0;
      b_id = '0; b_resp = '0; b_user = '0; b_valid = 1'b0;
      ar_ready = 1'b0;
      r_id = '0; r_data = '0; r_resp = '0; r_last = 1'b1; r_user = '0; r_valid = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_aw_backpressure();
      test_error();
      test_busy_req();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
